// File: rtl/mmio_uart_tx_if.sv
// Core data-bus connection for the memory-mapped UART transmitter.
//   memory_read  : Core read strobe
//   memory_write : Core write strobe
//   address      : Core byte address
//   write_data   : Core write data
//   read_data    : register read data, 0 when the window is not selected
// master modport is the Core side, slave modport is the peripheral side.
interface mmio_uart_tx_if;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output memory_read,
    output memory_write,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  memory_read,
    input  memory_write,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a small TX FIFO.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : Core data-bus slave (memory_read/memory_write/address/write_data/read_data)
//   tx    : serial output, idle high
// Register window (8 bytes at BASE_ADDRESS):
//   0x0 TXDATA : write pushes write_data[7:0]; reads 0
//   0x4 STATUS : {count[15:8], parity_en[4], overflow[3], empty[2], full[1], busy[0]};
//                any write clears overflow
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit and makes STATUS bit4 read 1.
module mmio_uart_tx #(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t              state_q, state_nx;
  logic [BAUD_W-1:0]   baud_q, baud_nx;
  logic [2:0]          bit_q, bit_nx;
  logic [7:0]          shift_q, shift_nx;
  logic                tx_q, tx_nx;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_nx;
`endif

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;
  logic [31:0]         read_data_q;

  logic                sel, full, empty, busy;
  logic                push_req, push, pop_c, status_wr;
  logic                baud_done;
  logic [7:0]          head;
  logic [31:0]         status;
  logic                unused_bus_bits;

  // Address decode and FIFO flags
  assign sel       = (bus.address[31:3] == BASE_ADDRESS[31:3]);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != ST_IDLE);
  assign push_req  = bus.memory_write && sel && !bus.address[2];
  assign push      = push_req && !full;
  assign status_wr = bus.memory_write && sel && bus.address[2];
  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign head      = mem[rd_ptr_q];

  assign unused_bus_bits = ^{bus.address[1:0], bus.write_data[31:8]};

  assign status = {16'h0000, 8'(count_q), 3'b000, PARITY_FLAG,
                   overflow_q, empty, full, busy};

  assign bus.read_data = read_data_q;
  assign tx            = tx_q;

  // FIFO storage: data only, validity is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.write_data[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow; a full FIFO drops the push
  // even if the transmitter pops in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full) begin
        overflow_q <= 1'b1;
      end else if (status_wr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Registered read port, zero when not selected so it can be OR-ed with Memory
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data_q <= '0;
    end else if (bus.memory_read && sel && bus.address[2]) begin
      read_data_q <= status;
    end else begin
      read_data_q <= '0;
    end
  end

  // State register with transmitter datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_nx;
      baud_q   <= baud_nx;
      bit_q    <= bit_nx;
      shift_q  <= shift_nx;
      tx_q     <= tx_nx;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_nx;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:   if (!empty)   state_nx = ST_START;
      ST_START:  if (baud_done) state_nx = ST_DATA;
      ST_DATA: begin
        if (baud_done && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_nx = ST_PARITY;
`else
          state_nx = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_done) state_nx = ST_STOP;
`endif
      ST_STOP:   if (baud_done) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output and datapath logic; tx is computed from the next state so the
  // registered line changes on the same edge as the state
  always_comb begin
    baud_nx   = baud_done ? '0 : baud_q + BAUD_W'(1);
    bit_nx    = bit_q;
    shift_nx  = shift_q;
    pop_c     = 1'b0;
    tx_nx     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_nx = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_nx = '0;
        if (!empty) begin
          pop_c     = 1'b1;
          shift_nx  = head;
          bit_nx    = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_nx = ^head;
`endif
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          shift_nx = {1'b0, shift_q[7:1]};
          bit_nx   = bit_q + 3'd1;
        end
      end
      default: ;
    endcase

    // Every state change restarts the bit period
    if (state_nx != state_q) begin
      baud_nx = '0;
    end

    case (state_nx)
      ST_IDLE:   tx_nx = 1'b1;
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nx = parity_nx;
`endif
      ST_STOP:   tx_nx = 1'b1;
      default:   tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_FREQ=4, BIT_RATE=1 (4 clocks per bit).
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          CPB  = 4;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PAR        = 32'h0000_0010;
  localparam int          FRAME_BITS = 11;
`else
  localparam logic [31:0] PAR        = 32'h0000_0000;
  localparam int          FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tx;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLK_FREQ     (4),
    .BIT_RATE     (1),
    .FIFO_DEPTH   (8),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.memory_write = 1'b1;
    bus.address      = addr;
    bus.write_data   = data;
    @(negedge clk);
    bus.memory_write = 1'b0;
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.memory_read = 1'b1;
    bus.address     = addr;
    @(negedge clk);
    data            = bus.read_data;
    bus.memory_read = 1'b0;
    bus.address     = 32'h0;
  endtask

  // Waits (at negedges) for tx to go low; lat == limit means no start bit seen.
  task automatic wait_start(input int limit, output int lat);
    lat = 0;
    while (tx !== 1'b0 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Captures one frame, sampling every cycle; shape_ok requires each bit to
  // hold for exactly CPB samples with correct start/stop levels.
  task automatic get_frame(input int limit, output int lat, output int t0,
                           output logic [7:0] b, output logic par, output logic shape_ok);
    b        = 8'h00;
    par      = 1'b0;
    shape_ok = 1'b0;
    t0       = 0;
    wait_start(limit, lat);
    if (lat >= limit) return;
    t0       = cyc;
    shape_ok = 1'b1;
    for (int c = 1; c < CPB; c++) begin
      @(negedge clk);
      if (tx !== 1'b0) shape_ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (c == 0) b[i] = tx;
        else if (tx !== b[i]) shape_ok = 1'b0;
      end
    end
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      if (c == 0) par = tx;
      else if (tx !== par) shape_ok = 1'b0;
    end
`endif
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) shape_ok = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  exp_b [9];
    logic        par, ok;
    int          lat, t0, t1;

    bus.memory_read  = 1'b0;
    bus.memory_write = 1'b0;
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;
    reset            = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_read_data", bus.read_data, 32'h0);
    reset = 1'b1;
    bus_read(BASE + 32'h4, rd);
    check("reset_status", rd, 32'h4 | PAR);

    // Single frame 0x55
    bus_write(BASE, 32'h55);
    fork
      get_frame(20, lat, t0, b, par, ok);
      begin
        repeat (12) @(negedge clk);
        bus_read(BASE + 32'h4, rd);
        check("busy_mid_frame", rd, 32'h5 | PAR);
      end
    join
    check("f55_latency", 32'(lat), 32'd1);
    check("f55_data", 32'(b), 32'h55);
    check("f55_shape", 32'(ok), 32'h1);
`ifdef UART_TX_PARITY_EN
    check("f55_parity", 32'(par), 32'h0);
`endif
    bus_read(BASE + 32'h4, rd);
    check("status_after_frame", rd, 32'h4 | PAR);

    // Back-to-back frames 0xA5, 0x3C
    fork
      begin
        get_frame(20, lat, t0, b, par, ok);
        check("fa5_data", 32'(b), 32'hA5);
        check("fa5_shape", 32'(ok), 32'h1);
        get_frame(20, lat, t1, b, par, ok);
        check("f3c_data", 32'(b), 32'h3C);
        check("f3c_shape", 32'(ok), 32'h1);
        check("frame_pitch", 32'(t1 - t0), 32'(FRAME_BITS * CPB + 1));
      end
      begin
        bus_write(BASE, 32'hA5);
        bus_write(BASE, 32'h3C);
        repeat (5) @(negedge clk);
        bus_read(BASE + 32'h4, rd);
        check("status_count1", rd, 32'h0000_0101 | PAR);
        repeat (50) @(negedge clk);
        bus_read(BASE + 32'h4, rd);
        check("status_count0", rd, 32'h0000_0005 | PAR);
      end
    join

    // Overflow: 0xFF in flight, then 9 writes into a depth-8 FIFO
    exp_b[0] = 8'hFF;
    for (int i = 1; i < 9; i++) exp_b[i] = 8'(i - 1);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          get_frame(100, lat, t0, b, par, ok);
          check($sformatf("ovf_frame%0d_data", i), 32'(b), 32'(exp_b[i]));
          check($sformatf("ovf_frame%0d_shape", i), 32'(ok), 32'h1);
        end
        wait_start(60, lat);
        check("dropped_byte_not_sent", 32'(lat), 32'd60);
      end
      begin
        bus_write(BASE, 32'hFF);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) bus_write(BASE, 32'(i));
        bus_read(BASE + 32'h4, rd);
        check("status_full_ovf", rd, 32'h0000_080B | PAR);
        bus_write(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, rd);
        check("status_ovf_cleared", rd, 32'h0000_0803 | PAR);
      end
    join

    // Read timing and address window
    @(negedge clk);
    bus.memory_read = 1'b1;
    bus.address     = BASE + 32'h5;
    check("rd_not_yet_valid", bus.read_data, 32'h0);
    @(negedge clk);
    bus.memory_read = 1'b0;
    bus.address     = 32'h0;
    check("rd_status_next_cycle", bus.read_data, 32'h4 | PAR);
    @(negedge clk);
    check("rd_zero_when_idle", bus.read_data, 32'h0);
    bus_write(BASE + 32'h8, 32'h41);
    bus_write(BASE - 32'h4, 32'h42);
    bus_read(BASE + 32'h4, rd);
    check("rd_status_again", rd, 32'h4 | PAR);
    bus_read(BASE + 32'h8, rd);
    check("rd_outside_window", rd, 32'h0);
    bus_read(BASE, rd);
    check("rd_txdata_zero", rd, 32'h0);
    wait_start(30, lat);
    check("no_frame_from_outside", 32'(lat), 32'd30);

    // Reset in the middle of the data bits with 3 bytes queued
    fork
      begin
        wait_start(50, lat);
        check("rst_frame_started", 32'(lat < 50), 32'h1);
        repeat (9) @(negedge clk);
        check("tx_in_bit1", 32'(tx), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("tx_after_reset", 32'(tx), 32'h1);
        @(negedge clk);
        reset = 1'b1;
      end
      begin
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        bus_write(BASE, 32'h33);
        bus_write(BASE, 32'h44);
      end
    join
    bus_read(BASE + 32'h4, rd);
    check("status_after_reset", rd, 32'h4 | PAR);
    wait_start(100, lat);
    check("no_frame_after_reset", 32'(lat), 32'd100);

`ifdef UART_TX_PARITY_EN
    // Parity frame 0x07: three ones gives parity 1
    bus_write(BASE, 32'h07);
    get_frame(20, lat, t0, b, par, ok);
    check("f07_data", 32'(b), 32'h07);
    check("f07_shape", 32'(ok), 32'h1);
    check("f07_parity", 32'(par), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
